id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline boundary for the 5-stage RV32I core. Registers the decoder's EX/MEM/WB control bits and the ID-stage operands, then presents them to EX one cycle later. Also owns load-use hazard detection and bubble insertion: it stalls PC and IF/ID on a load-use conflict and squashes the ID instruction when EX redirects on a taken branch or jump.

## Interface
Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_hold  in  1  memory wait; freezes this stage entirely.
- ex_redirect  in  1  taken branch/jump resolved in EX; squash ID.
- id_valid  in  1  ID holds a real instruction.
- id_ex_branch, id_ex_pc_sel, id_ex_lui_sel, id_wb_reg_write, id_wb_memtoreg, id_m_mem_read, id_m_mem_write  in  1 each  decoder control bits.
- id_ex_add2_sel, id_ex_alu_op  in  2 each  decoder selects.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID operands.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RADDR_W each.
- id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
- id_funct3  in  3;  id_funct7_5  in  1.
- ex_*  out  same widths  registered copies of every id_* input above except id_rs*_used; ex_valid  out  1.
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational).
- bubble_cnt  out  32  count of inserted bubbles.

## Operation
- Bubble value: ex_valid, ex_branch, ex_pc_sel, ex_lui_sel, ex_wb_reg_write, ex_wb_memtoreg, ex_m_mem_read and ex_m_mem_write = 0; ex_add2_sel = `ADD2_RS2; ex_alu_op = `ALU_OP_R; all data and address fields = 0.
- Load-use detection: luh = ex_valid & ex_m_mem_read & (ex_rd_addr != 0) & ((id_rs1_used & id_rs1_addr == ex_rd_addr) | (id_rs2_used & id_rs2_addr == ex_rd_addr)) & id_valid.
- Per-edge priority:
  - mem_hold: all registers keep their values.
  - Otherwise, ex_redirect: load a bubble.
  - Otherwise, luh: load a bubble.
  - Otherwise: load id_* unchanged. If id_valid = 0, the control bits are forced to the bubble value.
- stall_if_id = luh & ~ex_redirect & ~mem_hold. mem_hold is handled upstream by its own path.
- bubble_cnt increments by 1, wrapping at 2^32, on every edge that loads a bubble due to ex_redirect or luh. It does not increment on invalid-ID loads or during mem_hold.
- A load to x0 never stalls.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- stall_if_id is combinational from ex_* registers and id_* addresses in the same cycle. A load-use stalls exactly one cycle; on the next cycle the EX bubble clears luh.
- Reset (asynchronous, rst_n low): all ex_* take the bubble value, bubble_cnt = 0, stall_if_id = 0. Reset may arrive mid-stall; the first post-reset edge behaves normally.
- Simultaneous ex_redirect and luh: redirect wins, stall_if_id = 0, and bubble_cnt increments once.
- mem_hold together with ex_redirect: nothing changes. The redirect remains asserted by the frozen EX stage and is taken once mem_hold drops.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, stall_if_id and the luh bubble behave as above.
- HAZARD_DETECT_EN undefined: luh is tied to 0 and stall_if_id is tied to 0. Software must schedule a NOP after loads. Redirect squash and bubble_cnt (redirect only) remain.

## Structure
- `ADD2_*, `ALU_OP_* and the RV32I opcode constants stay in the shared defines.v, which this block includes.
- The bubble value of add2_sel and alu_op is added to defines.v as `BUBBLE_ADD2_SEL and `BUBBLE_ALU_OP.
- Sub-module hazard_detect: purely combinational luh/stall_if_id. It is compiled as a constant 0 when HAZARD_DETECT_EN is off.
- The top holds the registers and bubble_cnt.

## Test plan
- Reset low mid-run with stall active: all ex_* outputs show the bubble value, bubble_cnt = 0 and stall_if_id = 0 immediately, before any clock edge.
- lw x5 followed by add x6,x5,x7: stall_if_id = 1 for exactly one cycle, then ex_valid = 0 for one cycle. The add reaches EX with ex_rs1_addr = 5. bubble_cnt = 1.
- lw x0 followed by add x6,x0,x0: no stall; the add enters EX on the next cycle.
- ex_redirect = 1 with a valid ID add: the next cycle shows ex_valid = 0 and ex_wb_reg_write = 0; bubble_cnt increments.
- ex_redirect and luh in the same cycle: stall_if_id = 0, a single bubble is loaded, and bubble_cnt increments by 1.
- mem_hold = 1 for 3 cycles with changing id_* inputs: ex_* stay constant and bubble_cnt is unchanged. Build with HAZARD_DETECT_EN undefined: a load-use pair produces no stall and bubble_cnt stays 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline boundary.
// Holds the ADD2/ALU_OP select encodings and their bubble values.
package id_ex_stage_pkg;

    localparam logic [1:0] ADD2_RS2 = 2'd0;
    localparam logic [1:0] ALU_OP_R = 2'd2;

    localparam logic [1:0] BUBBLE_ADD2_SEL = ADD2_RS2;
    localparam logic [1:0] BUBBLE_ALU_OP   = ALU_OP_R;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       pc_sel;
        logic       lui_sel;
        logic       wb_reg_write;
        logic       wb_memtoreg;
        logic       m_mem_read;
        logic       m_mem_write;
        logic [1:0] add2_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c          = '0;
        c.add2_sel = BUBBLE_ADD2_SEL;
        c.alu_op   = BUBBLE_ALU_OP;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the ID/EX register and EX.
// master = ID/EX-control side (drives id_*), slave = the id_ex_stage block.
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    // No valid/ready pair: id_* is sampled on every edge unless mem_hold is high;
    // stall_if_id asks upstream to present the same instruction again next cycle.
    logic               mem_hold;
    logic               ex_redirect;
    logic               id_valid;
    logic               id_ex_branch;
    logic               id_ex_pc_sel;
    logic               id_ex_lui_sel;
    logic               id_wb_reg_write;
    logic               id_wb_memtoreg;
    logic               id_m_mem_read;
    logic               id_m_mem_write;
    logic [1:0]         id_ex_add2_sel;
    logic [1:0]         id_ex_alu_op;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic [RADDR_W-1:0] id_rs1_addr;
    logic [RADDR_W-1:0] id_rs2_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [2:0]         id_funct3;
    logic               id_funct7_5;

    logic               ex_valid;
    logic               ex_branch;
    logic               ex_pc_sel;
    logic               ex_lui_sel;
    logic               ex_wb_reg_write;
    logic               ex_wb_memtoreg;
    logic               ex_m_mem_read;
    logic               ex_m_mem_write;
    logic [1:0]         ex_add2_sel;
    logic [1:0]         ex_alu_op;
    logic [XLEN-1:0]    ex_pc;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic [RADDR_W-1:0] ex_rs1_addr;
    logic [RADDR_W-1:0] ex_rs2_addr;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic [2:0]         ex_funct3;
    logic               ex_funct7_5;

    logic               stall_if_id;
    logic [31:0]        bubble_cnt;

    modport master (
        output mem_hold, ex_redirect, id_valid,
        output id_ex_branch, id_ex_pc_sel, id_ex_lui_sel, id_wb_reg_write, id_wb_memtoreg,
        output id_m_mem_read, id_m_mem_write, id_ex_add2_sel, id_ex_alu_op,
        output id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_used, id_rs2_used,
        output id_funct3, id_funct7_5,
        input  ex_valid, ex_branch, ex_pc_sel, ex_lui_sel, ex_wb_reg_write, ex_wb_memtoreg,
        input  ex_m_mem_read, ex_m_mem_write, ex_add2_sel, ex_alu_op,
        input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_funct7_5,
        input  stall_if_id, bubble_cnt
    );

    modport slave (
        input  mem_hold, ex_redirect, id_valid,
        input  id_ex_branch, id_ex_pc_sel, id_ex_lui_sel, id_wb_reg_write, id_wb_memtoreg,
        input  id_m_mem_read, id_m_mem_write, id_ex_add2_sel, id_ex_alu_op,
        input  id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_used, id_rs2_used,
        input  id_funct3, id_funct7_5,
        output ex_valid, ex_branch, ex_pc_sel, ex_lui_sel, ex_wb_reg_write, ex_wb_memtoreg,
        output ex_m_mem_read, ex_m_mem_write, ex_add2_sel, ex_alu_op,
        output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_funct7_5,
        output stall_if_id, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection for the ID/EX boundary.
// Active only when HAZARD_DETECT_EN is defined; otherwise both outputs are constant 0.
module id_ex_stage_hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               i_ex_valid,
    input  logic               i_ex_mem_read,
    input  logic [RADDR_W-1:0] i_ex_rd_addr,
    input  logic               i_id_valid,
    input  logic [RADDR_W-1:0] i_id_rs1_addr,
    input  logic [RADDR_W-1:0] i_id_rs2_addr,
    input  logic               i_id_rs1_used,
    input  logic               i_id_rs2_used,
    input  logic               i_ex_redirect,
    input  logic               i_mem_hold,
    output logic               o_luh,
    output logic               o_stall
);
`ifdef HAZARD_DETECT_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
    // A load to x0 never produces a value, so it never stalls.
    assign o_luh   = i_ex_valid & i_ex_mem_read & (i_ex_rd_addr != '0)
                   & (w_rs1_hit | w_rs2_hit) & i_id_valid;
    assign o_stall = o_luh & ~i_ex_redirect & ~i_mem_hold;
`else
    logic w_unused;

    assign w_unused = &{1'b0, i_ex_valid, i_ex_mem_read, i_ex_rd_addr, i_id_valid,
                        i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
                        i_ex_redirect, i_mem_hold};
    assign o_luh   = 1'b0;
    assign o_stall = 1'b0;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and redirect squash.
// Load-use detection is compiled in only when HAZARD_DETECT_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    ctrl_t              r_ctrl;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_rs1_data;
    logic [XLEN-1:0]    r_rs2_data;
    logic [XLEN-1:0]    r_imm;
    logic [RADDR_W-1:0] r_rs1_addr;
    logic [RADDR_W-1:0] r_rs2_addr;
    logic [RADDR_W-1:0] r_rd_addr;
    logic [2:0]         r_funct3;
    logic               r_funct7_5;
    logic [31:0]        r_bubble_cnt;

    ctrl_t w_id_ctrl;
    logic  w_luh;
    logic  w_stall;

    always_comb begin
        w_id_ctrl              = bubble_ctrl();
        if (bus.id_valid) begin
            w_id_ctrl.valid        = 1'b1;
            w_id_ctrl.branch       = bus.id_ex_branch;
            w_id_ctrl.pc_sel       = bus.id_ex_pc_sel;
            w_id_ctrl.lui_sel      = bus.id_ex_lui_sel;
            w_id_ctrl.wb_reg_write = bus.id_wb_reg_write;
            w_id_ctrl.wb_memtoreg  = bus.id_wb_memtoreg;
            w_id_ctrl.m_mem_read   = bus.id_m_mem_read;
            w_id_ctrl.m_mem_write  = bus.id_m_mem_write;
            w_id_ctrl.add2_sel     = bus.id_ex_add2_sel;
            w_id_ctrl.alu_op       = bus.id_ex_alu_op;
        end
    end

    id_ex_stage_hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard_detect (
        .i_ex_valid    (r_ctrl.valid),
        .i_ex_mem_read (r_ctrl.m_mem_read),
        .i_ex_rd_addr  (r_rd_addr),
        .i_id_valid    (bus.id_valid),
        .i_id_rs1_addr (bus.id_rs1_addr),
        .i_id_rs2_addr (bus.id_rs2_addr),
        .i_id_rs1_used (bus.id_rs1_used),
        .i_id_rs2_used (bus.id_rs2_used),
        .i_ex_redirect (bus.ex_redirect),
        .i_mem_hold    (bus.mem_hold),
        .o_luh         (w_luh),
        .o_stall       (w_stall)
    );

    // Redirect outranks a load-use: either way one bubble and one count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl       <= bubble_ctrl();
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1_addr   <= '0;
            r_rs2_addr   <= '0;
            r_rd_addr    <= '0;
            r_funct3     <= '0;
            r_funct7_5   <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (!bus.mem_hold) begin
            if (bus.ex_redirect || w_luh) begin
                r_ctrl       <= bubble_ctrl();
                r_pc         <= '0;
                r_rs1_data   <= '0;
                r_rs2_data   <= '0;
                r_imm        <= '0;
                r_rs1_addr   <= '0;
                r_rs2_addr   <= '0;
                r_rd_addr    <= '0;
                r_funct3     <= '0;
                r_funct7_5   <= 1'b0;
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end else begin
                r_ctrl       <= w_id_ctrl;
                r_pc         <= bus.id_pc;
                r_rs1_data   <= bus.id_rs1_data;
                r_rs2_data   <= bus.id_rs2_data;
                r_imm        <= bus.id_imm;
                r_rs1_addr   <= bus.id_rs1_addr;
                r_rs2_addr   <= bus.id_rs2_addr;
                r_rd_addr    <= bus.id_rd_addr;
                r_funct3     <= bus.id_funct3;
                r_funct7_5   <= bus.id_funct7_5;
            end
        end
    end

    assign bus.ex_valid        = r_ctrl.valid;
    assign bus.ex_branch       = r_ctrl.branch;
    assign bus.ex_pc_sel       = r_ctrl.pc_sel;
    assign bus.ex_lui_sel      = r_ctrl.lui_sel;
    assign bus.ex_wb_reg_write = r_ctrl.wb_reg_write;
    assign bus.ex_wb_memtoreg  = r_ctrl.wb_memtoreg;
    assign bus.ex_m_mem_read   = r_ctrl.m_mem_read;
    assign bus.ex_m_mem_write  = r_ctrl.m_mem_write;
    assign bus.ex_add2_sel     = r_ctrl.add2_sel;
    assign bus.ex_alu_op       = r_ctrl.alu_op;
    assign bus.ex_pc           = r_pc;
    assign bus.ex_rs1_data     = r_rs1_data;
    assign bus.ex_rs2_data     = r_rs2_data;
    assign bus.ex_imm          = r_imm;
    assign bus.ex_rs1_addr     = r_rs1_addr;
    assign bus.ex_rs2_addr     = r_rs2_addr;
    assign bus.ex_rd_addr      = r_rd_addr;
    assign bus.ex_funct3       = r_funct3;
    assign bus.ex_funct7_5     = r_funct7_5;
    assign bus.stall_if_id     = w_stall;
    assign bus.bubble_cnt      = r_bubble_cnt;
endmodule
